fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
// - Shares one FIFO instance (data_in/insert/next/clear/full/empty) between NUM_REQ producers with round-robin arbitration.
// - Gates the consumer-side pop and sequences FIFO clears, on reset and on request. The FIFO itself has no reset.
// - Sits between the producer units and the FIFO. The consumer reads through this block.
// PARAMETERS
// - data_width  32  width of one producer word
// - NUM_REQ      4  number of producers, 2..16
// - IDX_W        2  clog2(NUM_REQ); the integrator must keep it consistent with NUM_REQ
// PORTS
// - clk            in   1              single clock; all state updates on posedge
// - reset          in   1              synchronous, active-high
// - req            in   NUM_REQ        producer i holds req[i] until it sees ack[i]
// - req_data       in   NUM_REQ*data_width  word i at [i*data_width +: data_width]
// - ack            out  NUM_REQ        one-hot; word i is taken at this clock edge
// - flush          in   1              request to empty the FIFO (sampled in RUN only)
// - flush_done     out  1              1-cycle pulse when the clear sequence ends
// - rd_en          in   1              consumer pops the head word
// - rd_valid       out  1              head word is valid
// - rd_data        out  data_width     head word, straight from fifo_data_out
// - fifo_data_in   out  FW             FW = data_width, or data_width+IDX_W with the tag option
// - fifo_data_out  in   FW             FIFO head
// - fifo_insert / fifo_next / fifo_clear  out 1  FIFO controls
// - fifo_full / fifo_empty                in  1  FIFO status
// BEHAVIOUR
// - FSM states: CLR, SETTLE, RUN.
//   - reset=1: next state is CLR, rr_ptr is 0. Combinationally, fifo_clear=1 and every other output is 0.
//   - CLR: fifo_clear=1; no insert, no next, no ack; next state SETTLE.
//   - SETTLE: flush_done=1 for this cycle only; no insert, no next; next state RUN.
//   - RUN with flush=1: no grant this cycle, fifo_next=0; next state CLR.
//   - Net effect: the FIFO is cleared one cycle after reset is released.
// - Read side, RUN only (outputs are 0 in every other state):
//   - rd_valid = ~fifo_empty
//   - fifo_next = rd_en & ~fifo_empty; rd_en while empty is ignored
// - Accept condition, RUN only: space = ~fifo_full | fifo_next.
//   - Insert while full is allowed only together with a pop; the FIFO shifts and appends in that cycle, so the count is unchanged.
// - Grant, combinational, zero latency:
//   - Pick the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
//   - The grant is valid only when space=1 and the state is RUN.
//   - ack[i]=1, fifo_insert=1, fifo_data_in=req_data[i].
// - rr_ptr: after a grant to i, rr_ptr <= (i+1) mod NUM_REQ; it is unchanged when there is no grant.
//   - Wrap rule: a grant to NUM_REQ-1 sets rr_ptr to 0.
// - Fairness: with every req held high, each producer is granted once in every NUM_REQ accepted words.
// - No grant at all when full without a pop, when no req is high, or in any non-RUN state.
// - reset or flush mid-stream: pending reqs stay unacked and are served after RUN is re-entered; words already in the FIFO are discarded.
// - ack is never asserted for a req that is 0. At most one ack and one insert per cycle.
// CONFIGURATION
// - Macro FIFO_ARB_TAG_EN.
//   - Defined: FW = data_width+IDX_W. fifo_data_in = {grant_idx, req_data[i]}.
//   - Defined: extra output rd_src [IDX_W-1:0] = fifo_data_out[FW-1 -: IDX_W]; rd_data = the low data_width bits.
//   - Undefined: FW = data_width, no rd_src port, the data path is passed through unchanged.
// TESTING
// - Reset: hold reset 3 cycles, then release -> fifo_clear=1 during reset and the 1st cycle after; flush_done=1 on the 2nd; first ack possible on the 3rd.
// - Round-robin: req=4'b1111 held, FIFO far from full -> ack sequence 0,1,2,3,0,1 on consecutive cycles; the FIFO holds req_data in that order.
// - Priority rotation: req=4'b1010 held -> acks alternate 1,3,1,3. Then drop req[3] -> ack on 1 every cycle, rr_ptr reads 2 after each grant.
// - Full boundary: fill to size=32 with rd_en=0, then req[0]=1:
//   - no ack while full;
//   - with rd_en=1, ack[0]=1 in the same cycle; fifo_full stays 1 and the head advances.
// - Flush mid-stream: 5 words queued, req[2]=1 and flush=1 in the same cycle:
//   - no ack that cycle; fifo_clear the next cycle; flush_done one cycle later;
//   - fifo_empty=1; then ack[2] in the first RUN cycle.
// - Tag option (FIFO_ARB_TAG_EN): words from requesters 3 then 1 -> rd_src reads 3 then 1 as rd_en pops them; rd_data matches each word.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO; also gates consumer pops and sequences FIFO clears.
// Optional source tagging of stored words is enabled with the FIFO_ARB_TAG_EN macro.
module fifo_write_arbiter #(
  parameter int data_width = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2
`ifdef FIFO_ARB_TAG_EN
  , localparam int FW      = data_width + IDX_W
`else
  , localparam int FW      = data_width
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          flush,
  output logic                          flush_done,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [data_width-1:0]         rd_data,
`ifdef FIFO_ARB_TAG_EN
  output logic [IDX_W-1:0]              rd_src,
`endif
  output logic [FW-1:0]                 fifo_data_in,
  input  logic [FW-1:0]                 fifo_data_out,
  output logic                          fifo_insert,
  output logic                          fifo_next,
  output logic                          fifo_clear,
  input  logic                          fifo_full,
  input  logic                          fifo_empty
);

  typedef enum logic [1:0] {ST_CLR, ST_SETTLE, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [data_width-1:0] grant_word;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign grant_word = req_data[int'(grant_idx)*data_width +: data_width];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    ack          = '0;
    fifo_insert  = 1'b0;
    fifo_next    = 1'b0;
    fifo_clear   = 1'b0;
    fifo_data_in = '0;
    flush_done   = 1'b0;
    rd_valid     = 1'b0;
    case (state_q)
      ST_CLR: begin
        fifo_clear = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        rd_valid = ~fifo_empty;
        if (flush) begin
          state_d = ST_CLR;
        end else begin
          fifo_next = rd_en & ~fifo_empty;
          // A full FIFO still accepts a word when the head is popped in the same cycle.
          if (grant_found && (~fifo_full | fifo_next)) begin
            ack[grant_idx] = 1'b1;
            fifo_insert    = 1'b1;
`ifdef FIFO_ARB_TAG_EN
            fifo_data_in   = {grant_idx, grant_word};
`else
            fifo_data_in   = grant_word;
`endif
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : IDX_W'(int'(grant_idx) + 1);
          end
        end
      end
      default: state_d = ST_CLR;
    endcase
    if (reset) begin
      state_d      = ST_CLR;
      rr_ptr_d     = '0;
      ack          = '0;
      fifo_insert  = 1'b0;
      fifo_next    = 1'b0;
      fifo_data_in = '0;
      flush_done   = 1'b0;
      rd_valid     = 1'b0;
      fifo_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CLR;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FIFO_ARB_TAG_EN
  assign rd_src  = fifo_data_out[FW-1 -: IDX_W];
  assign rd_data = fifo_data_out[data_width-1:0];
`else
  assign rd_data = fifo_data_out;
`endif

endmodule
